// File: rtl/fifo_ptr_ctrl.sv
// Pointer/arbitration controller for a 16-entry single-port FIFO.
// Round-robin write/read grants share one memory port; status derives from the pointers.
module fifo_ptr_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_req,
  input  logic       rd_req,
  output logic       wr_ack,
  output logic       rd_ack,
  output logic       addr_sel,
  output logic [4:0] wr_ptr,
  output logic [4:0] rd_ptr,
  output logic       mem_we,
  output logic       rd_valid,
  output logic       full,
  output logic       empty,
  output logic [4:0] count,
  output logic       ovf,
  output logic       udf
);

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_e;

  logic [4:0] r_wr_ptr;
  logic [4:0] r_rd_ptr;
  grant_e     r_last_grant;
  logic       r_rd_valid;
  logic       r_ovf;
  logic       r_udf;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;
  logic w_grant_wr;
  logic w_grant_rd;

  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[4] != r_rd_ptr[4]) && (r_wr_ptr[3:0] == r_rd_ptr[3:0]);
    w_wr_ok = wr_req & ~w_full;
    w_rd_ok = rd_req & ~w_empty;
    // On contention the side that did not win last time gets the port.
    w_grant_wr = rst_n & w_wr_ok & (~w_rd_ok | (r_last_grant == GRANT_RD));
    w_grant_rd = rst_n & w_rd_ok & (~w_wr_ok | (r_last_grant == GRANT_WR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_last_grant <= GRANT_RD;
      r_rd_valid   <= 1'b0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
    end else begin
      r_rd_valid <= w_grant_rd;
      r_ovf      <= r_ovf | (wr_req & w_full);
      r_udf      <= r_udf | (rd_req & w_empty);
      if (w_grant_wr) begin
        r_wr_ptr     <= r_wr_ptr + 5'd1;
        r_last_grant <= GRANT_WR;
      end else if (w_grant_rd) begin
        r_rd_ptr     <= r_rd_ptr + 5'd1;
        r_last_grant <= GRANT_RD;
      end
    end
  end

  assign wr_ack   = w_grant_wr;
  assign rd_ack   = w_grant_rd;
  assign mem_we   = w_grant_wr;
  assign addr_sel = w_grant_wr;
  assign wr_ptr   = r_wr_ptr;
  assign rd_ptr   = r_rd_ptr;
  assign rd_valid = r_rd_valid;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_wr_ptr - r_rd_ptr;
  assign ovf      = r_ovf;
  assign udf      = r_udf;

endmodule
